seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner_if.sv | 23 ++
 rtl/seven_seg_scanner.sv | 112 +++++++++++
 tb/tb_seven_seg_scanner.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for seven_seg_scanner: BCD time digits in, multiplexed segment/anode pins out.
// The slave modport is the scanner; the master modport is whoever supplies digits and watches the pins.
interface seven_seg_scanner_if;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [3:0] hour_ones;
  logic [3:0] hour_tens;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  modport master (
    output sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
    input  seg, dp, an
  );

  modport slave (
    input  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
    output seg, dp, an
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Six-digit time-multiplexed 7-segment driver with per-frame digit snapshot, anti-ghost blanking,
// leading-zero blanking, blinking colon points and a dash for non-BCD digits.
module seven_seg_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int GHOST_CYC  = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  seven_seg_scanner_if.slave disp
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic             prime_reg;
  logic [3:0]       snap_reg [6];
  logic [3:0]       din [6];
  logic             slot_wrap, snap_load;

  logic [6:0] seg_reg, seg_next;
  logic       dp_reg, dp_next;
  logic [5:0] an_reg, an_next;
  logic [3:0] cur_digit;
  logic [6:0] seg_raw;
  logic       dp_raw;
  logic [5:0] an_raw;

  assign din[0] = disp.sec_ones;
  assign din[1] = disp.sec_tens;
  assign din[2] = disp.min_ones;
  assign din[3] = disp.min_tens;
  assign din[4] = disp.hour_ones;
  assign din[5] = disp.hour_tens;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    slot_wrap = (cnt_reg == CNT_LAST);
    cnt_next  = cnt_reg + CNT_W'(1);
    idx_next  = idx_reg;
    if (slot_wrap) begin
      cnt_next = '0;
      idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end
    // Snapshot only at frame boundaries so a digit rollover never tears across slots.
    snap_load = prime_reg | (slot_wrap & (idx_reg == 3'd5));
  end

  always_comb begin
    cur_digit = snap_reg[idx_reg];
    seg_raw   = decode(cur_digit);
    if (BLANK_LZ && (idx_reg == 3'd5) && (snap_reg[5] == 4'd0))
      seg_raw = 7'h00;
    dp_raw = ((idx_reg == 3'd2) || (idx_reg == 3'd4)) && !snap_reg[0][0];
    an_raw = (cnt_reg < CNT_GHOST) ? 6'h00 : (6'h01 << idx_reg);
    seg_next = seg_raw ^ {7{ACTIVE_LOW}};
    dp_next  = dp_raw ^ ACTIVE_LOW;
    an_next  = an_raw ^ {6{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      prime_reg <= 1'b1;
      seg_reg   <= {7{ACTIVE_LOW}};
      dp_reg    <= ACTIVE_LOW;
      an_reg    <= {6{ACTIVE_LOW}};
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      prime_reg <= 1'b0;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (reset)
          snap_reg[gi] <= 4'd0;
        else if (snap_load)
          snap_reg[gi] <= din[gi];
      end
    end
  endgenerate

  assign disp.seg = seg_reg;
  assign disp.dp  = dp_reg;
  assign disp.an  = an_reg;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: directed digit patterns queue per-slot expectations; a negedge monitor
// pops one entry at the start of every enabled slot and checks hold, length and one-hot anodes.
module tb_seven_seg_scanner;
  localparam int SD = 8;
  localparam int GC = 2;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t exp_q[$];

  seven_seg_scanner_if bus();
  seven_seg_scanner_if bus_nb();
  seven_seg_scanner_if bus_al();

  seven_seg_scanner #(.SCAN_DIV(SD), .GHOST_CYC(GC), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1))
    u_dut (.clk(clk), .reset(reset), .disp(bus));
  seven_seg_scanner #(.SCAN_DIV(SD), .GHOST_CYC(GC), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0))
    u_dut_nb (.clk(clk), .reset(reset), .disp(bus_nb));
  seven_seg_scanner #(.SCAN_DIV(SD), .GHOST_CYC(GC), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
    u_dut_al (.clk(clk), .reset(reset), .disp(bus_al));

  always #5 clk = ~clk;

  // Reset as the DUT saw it at the last edge, so the monitor knows outputs were forced inactive.
  always @(posedge clk) rst_q <= reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic push_slot(input logic [5:0] an, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    exp_q.push_back(e);
  endtask

  task automatic set_main(input logic [3:0] ht, input logic [3:0] ho, input logic [3:0] mt,
                          input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so);
    bus.hour_tens = ht;
    bus.hour_ones = ho;
    bus.min_tens  = mt;
    bus.min_ones  = mo;
    bus.sec_tens  = st;
    bus.sec_ones  = so;
  endtask

  // Monitor: one transaction per enabled slot.
  initial begin
    bit   active = 0;
    int   len = 0;
    exp_t cur;
    exp_t got;
    exp_t want;
    forever begin
      @(negedge clk);
      got.an  = bus.an;
      got.seg = bus.seg;
      got.dp  = bus.dp;
      if (rst_q) begin
        active = 0;
      end else if (got.an != 6'h00) begin
        check("an_onehot", 32'($onehot(got.an)), 32'd1);
        if (!active) begin
          active = 1;
          len = 1;
          cur = got;
          $display("slot an=%02h seg=%02h dp=%0d t=%0t", got.an, got.seg, got.dp, $time);
          if (exp_q.size() == 0) begin
            check("unexpected_slot", 32'(got), 32'h0);
          end else begin
            want = exp_q.pop_front();
            check("slot_an", 32'(got.an), 32'(want.an));
            check("slot_seg", 32'(got.seg), 32'(want.seg));
            check("slot_dp", 32'(got.dp), 32'(want.dp));
          end
        end else begin
          len++;
          check("slot_hold", 32'(got), 32'(cur));
        end
      end else if (active) begin
        active = 0;
        check("slot_len", 32'(len), 32'(SD - GC));
      end
    end
  end

  initial begin
    set_main(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    bus_nb.hour_tens = 4'd0; bus_nb.hour_ones = 4'd9; bus_nb.min_tens = 4'd0;
    bus_nb.min_ones  = 4'd5; bus_nb.sec_tens  = 4'd0; bus_nb.sec_ones = 4'hA;
    bus_al.hour_tens = 4'd0; bus_al.hour_ones = 4'd0; bus_al.min_tens = 4'd0;
    bus_al.min_ones  = 4'd0; bus_al.sec_tens  = 4'd0; bus_al.sec_ones = 4'd5;

    repeat (3) step();
    check("rst_an", 32'(bus.an), 32'h00);
    check("rst_seg", 32'(bus.seg), 32'h00);
    check("rst_dp", 32'(bus.dp), 32'h0);
    check("rst_al_an", 32'(bus_al.an), 32'h3F);
    check("rst_al_seg", 32'(bus_al.seg), 32'h7F);
    check("rst_al_dp", 32'(bus_al.dp), 32'h1);

    // Frame 1: 12:34:56, seconds even so colon points lit.
    push_slot(6'h01, 7'h7D, 1'b0);
    push_slot(6'h02, 7'h6D, 1'b0);
    push_slot(6'h04, 7'h66, 1'b1);
    push_slot(6'h08, 7'h4F, 1'b0);
    push_slot(6'h10, 7'h5B, 1'b1);
    push_slot(6'h20, 7'h06, 1'b0);

    reset  = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("first_slot_an", 32'(bus.an), (e >= 3 && e <= 8) ? 32'h01 : 32'h00);
      if (e == 3) begin
        check("first_slot_seg", 32'(bus.seg), 32'h7D);
        check("pol_seg", 32'(bus_al.seg), 32'h12);
        check("pol_an", 32'(bus_al.an), 32'h3E);
        check("pol_dp", 32'(bus_al.dp), 32'h1);
      end
    end

    // Mid-frame change during slot 3 must wait for the next frame.
    while (edge_n < 27) step();
    set_main(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    for (int f = 0; f < 2; f++) begin
      push_slot(6'h01, 7'h6F, 1'b0);
      push_slot(6'h02, 7'h6D, 1'b0);
      push_slot(6'h04, 7'h6F, 1'b0);
      push_slot(6'h08, 7'h6D, 1'b0);
      push_slot(6'h10, 7'h4F, 1'b0);
      if (f == 0) push_slot(6'h20, 7'h5B, 1'b0);
    end

    while (edge_n < 45) step();
    check("nolz_an", 32'(bus_nb.an), 32'h20);
    check("nolz_seg", 32'(bus_nb.seg), 32'h3F);

    // Reset for one cycle in frame 3, slot 4.
    while (edge_n < 132) step();
    reset = 1'b1;
    step();
    check("midrst_an", 32'(bus.an), 32'h00);
    check("midrst_seg", 32'(bus.seg), 32'h00);
    check("midrst_dp", 32'(bus.dp), 32'h0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);

    set_main(4'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'hA);
    push_slot(6'h01, 7'h40, 1'b0);
    push_slot(6'h02, 7'h3F, 1'b0);
    push_slot(6'h04, 7'h6D, 1'b1);
    push_slot(6'h08, 7'h3F, 1'b0);
    push_slot(6'h10, 7'h6F, 1'b1);
    push_slot(6'h20, 7'h00, 1'b0);
    reset  = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 3; e++) begin
      step();
      check("restart_an", 32'(bus.an), (e == 3) ? 32'h01 : 32'h00);
    end

    while (edge_n < 50) step();
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
